// File: rtl/bit_packer_pkg.sv
// Shared types and width helpers for the bit packer and its placement rotator.
package bit_packer_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } packerState_e;

  function automatic int inUnits(input int inWidth, input int step);
    return inWidth / step;
  endfunction

  function automatic int outUnits(input int outWidth, input int step);
    return outWidth / step;
  endfunction

  function automatic int accWidth(input int inWidth, input int outWidth);
    return inWidth + outWidth;
  endfunction

  function automatic int accwUnits(input int inWidth, input int outWidth, input int step);
    return (inWidth + outWidth) / step;
  endfunction

  function automatic int countBits(input int units);
    return $clog2(units) + 1;
  endfunction

  localparam int DEF_INPUTWIDTH  = 16;
  localparam int DEF_OUTPUTWIDTH = 32;
  localparam int DEF_STEP        = 1;
  localparam int DEF_IN_COUNT_W  = countBits(inUnits(DEF_INPUTWIDTH, DEF_STEP));
  localparam int DEF_OUT_COUNT_W = countBits(outUnits(DEF_OUTPUTWIDTH, DEF_STEP));

endpackage

// File: rtl/bit_packer_rotator.sv
// Unit-granular right rotator and the interface that connects it to its user.
interface rotatorConnect #(
  parameter int WIDTH  = 48,
  parameter int SHIFTW = 6
);
  logic [WIDTH-1:0]  dataIn;
  logic [SHIFTW-1:0] shift;
  logic [WIDTH-1:0]  dataOut;

  modport shifter (input dataIn, input shift, output dataOut);
  modport user (output dataIn, output shift, input dataOut);
endinterface

module barrelShifterRight #(
  parameter int INPUTWIDTH         = 48,
  parameter int OUTPUTWIDTH        = 48,
  parameter int SHIFTBITS_PER_STEP = 1
) (
  rotatorConnect.shifter rot
);
  localparam int UNITS  = INPUTWIDTH / SHIFTBITS_PER_STEP;
  localparam int SHIFTW = $clog2(UNITS);

  logic [INPUTWIDTH-1:0] stage [0:SHIFTW];

  assign stage[0] = rot.dataIn;

  // Each stage rotates by a power-of-two number of units; amounts below UNITS compose exactly.
  for (genvar gi = 0; gi < SHIFTW; gi++) begin : gStage
    localparam int C = (1 << gi) * SHIFTBITS_PER_STEP;
    assign stage[gi+1] = rot.shift[gi] ? {stage[gi][C-1:0], stage[gi][INPUTWIDTH-1:C]}
                                       : stage[gi];
  end

  assign rot.dataOut = stage[SHIFTW][OUTPUTWIDTH-1:0];
endmodule

// File: rtl/bit_packer.sv
// Packs variable-length LSB-first fragments into full output words, with flush of the tail.
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int INPUTWIDTH         = 16,
  parameter int OUTPUTWIDTH        = 32,
  parameter int SHIFTBITS_PER_STEP = 1
) (
  input  logic                                             clk,
  input  logic                                             rstN,
  input  logic                                             inValid,
  output logic                                             inReady,
  input  logic [INPUTWIDTH-1:0]                            inData,
  input  logic [$clog2(INPUTWIDTH/SHIFTBITS_PER_STEP):0]   inCount,
  input  logic                                             inFlush,
  output logic                                             outValid,
  input  logic                                             outReady,
  output logic [OUTPUTWIDTH-1:0]                           outData,
  output logic [$clog2(OUTPUTWIDTH/SHIFTBITS_PER_STEP):0]  outCount
);
  localparam int IN_UNITS   = inUnits(INPUTWIDTH, SHIFTBITS_PER_STEP);
  localparam int OUT_UNITS  = outUnits(OUTPUTWIDTH, SHIFTBITS_PER_STEP);
  localparam int ACCW       = accWidth(INPUTWIDTH, OUTPUTWIDTH);
  localparam int ACCW_UNITS = accwUnits(INPUTWIDTH, OUTPUTWIDTH, SHIFTBITS_PER_STEP);
  localparam int IN_CW      = countBits(IN_UNITS);
  localparam int OUT_CW     = countBits(OUT_UNITS);
  localparam int FILL_W     = $clog2(ACCW_UNITS + 1);
  localparam int ROT_W      = $clog2(ACCW_UNITS);

  localparam logic [FILL_W-1:0] OUT_UNITS_F  = FILL_W'(OUT_UNITS);
  localparam logic [FILL_W-1:0] ACCW_UNITS_F = FILL_W'(ACCW_UNITS);
  localparam logic [IN_CW-1:0]  IN_UNITS_C   = IN_CW'(IN_UNITS);

  logic [ACCW-1:0]       accReg, accNext, accShifted;
  logic [FILL_W-1:0]     fillReg, fillNext, fillAfterOut, drainUnits;
  packerState_e          stateReg, stateNext;
  logic                  readyEnReg;
  logic [IN_CW-1:0]      unitCount;
  logic [INPUTWIDTH-1:0] maskedData;
  logic                  inFire, outFire;

  rotatorConnect #(.WIDTH(ACCW), .SHIFTW(ROT_W)) rotBus ();

  barrelShifterRight #(
    .INPUTWIDTH         (ACCW),
    .OUTPUTWIDTH        (ACCW),
    .SHIFTBITS_PER_STEP (SHIFTBITS_PER_STEP)
  ) uPlacer (
    .rot (rotBus.shifter)
  );

  // readyEnReg keeps inReady low through reset without a combinational path from rstN.
  assign inReady    = readyEnReg && (stateReg == FILL) && (fillReg < OUT_UNITS_F);
  assign outValid   = (stateReg == FILL) ? (fillReg >= OUT_UNITS_F) : (fillReg != '0);
  assign drainUnits = (fillReg > OUT_UNITS_F) ? OUT_UNITS_F : fillReg;
  assign outData    = accReg[OUTPUTWIDTH-1:0];
  assign outCount   = !outValid ? '0
                    : (stateReg == FILL) ? OUT_CW'(OUT_UNITS) : OUT_CW'(drainUnits);

  assign inFire  = inValid && inReady;
  assign outFire = outValid && outReady;

  assign unitCount = (inCount > IN_UNITS_C) ? IN_UNITS_C : inCount;

  for (genvar gi = 0; gi < IN_UNITS; gi++) begin : gMask
    assign maskedData[gi*SHIFTBITS_PER_STEP +: SHIFTBITS_PER_STEP] =
      (IN_CW'(gi) < unitCount) ? inData[gi*SHIFTBITS_PER_STEP +: SHIFTBITS_PER_STEP] : '0;
  end

  // The output shift happens first, so the fragment lands relative to the post-shift fill.
  assign fillAfterOut  = outFire ? (fillReg - drainUnits) : fillReg;
  assign accShifted    = outFire ? (accReg >> OUTPUTWIDTH) : accReg;
  assign rotBus.dataIn = {{OUTPUTWIDTH{1'b0}}, maskedData};
  assign rotBus.shift  = ROT_W'((fillAfterOut == '0) ? '0 : (ACCW_UNITS_F - fillAfterOut));
  assign accNext       = accShifted | (inFire ? rotBus.dataOut : '0);
  assign fillNext      = fillAfterOut + (inFire ? FILL_W'(unitCount) : '0);

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      FILL:    if (inFire && inFlush && (fillNext != '0)) stateNext = DRAIN;
      DRAIN:   if (fillNext == '0) stateNext = FILL;
      default: stateNext = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      accReg     <= '0;
      fillReg    <= '0;
      stateReg   <= FILL;
      readyEnReg <= 1'b0;
    end else begin
      accReg     <= accNext;
      fillReg    <= fillNext;
      stateReg   <= stateNext;
      readyEnReg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bit_packer.sv
// Directed and randomized checks of bit_packer against a bit-queue reference model.
module tb_bit_packer;
  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [7:0]  inData;
  logic [3:0]  inCount;
  logic        inFlush;
  logic        outValid;
  logic        outReady;
  logic [15:0] outData;
  logic [4:0]  outCount;

  int tests;
  int fails;

  bit bitsQ[$];
  int flushRemain;

  bit_packer #(
    .INPUTWIDTH         (8),
    .OUTPUTWIDTH        (16),
    .SHIFTBITS_PER_STEP (1)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (inData),
    .inCount  (inCount),
    .inFlush  (inFlush),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .outCount (outCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendBeat(input logic [7:0] d, input logic [3:0] c, input logic f);
    int waited;
    inValid = 1'b1;
    inData  = d;
    inCount = c;
    inFlush = f;
    waited  = 0;
    while (!inReady && waited < 20) begin
      tick();
      waited++;
    end
    if (!inReady) check("accept_timeout", 32'(inReady), 32'd1);
    tick();
    inValid = 1'b0;
    inFlush = 1'b0;
  endtask

  // Reference: pending stream is a queue of bits; a flush marks how many of them end the stream.
  task automatic modelCycle();
    logic        iFire, oFire;
    int          n, c;
    logic [15:0] expWord;
    check("rand_valid", 32'(outValid), 32'((bitsQ.size() >= 16) || (flushRemain > 0)));
    check("rand_ready", 32'(inReady), 32'((flushRemain == 0) && (bitsQ.size() < 16)));
    iFire = inValid && inReady;
    oFire = outValid && outReady;
    if (oFire) begin
      n = (flushRemain > 0 && flushRemain < 16) ? flushRemain : 16;
      if (bitsQ.size() < n) check("rand_underflow", 32'(bitsQ.size()), 32'(n));
      expWord = '0;
      for (int i = 0; i < n && bitsQ.size() > 0; i++) expWord[i] = bitsQ.pop_front();
      check("rand_data", 32'(outData), 32'(expWord));
      check("rand_count", 32'(outCount), 32'(n));
      if (flushRemain > 0) flushRemain -= n;
      if (flushRemain < 0) flushRemain = 0;
    end
    if (iFire) begin
      c = (inCount > 8) ? 8 : int'(inCount);
      for (int i = 0; i < c; i++) bitsQ.push_back(inData[i]);
      if (inFlush) flushRemain = bitsQ.size();
    end
    tick();
  endtask

  initial begin
    logic accepted;
    tests       = 0;
    fails       = 0;
    flushRemain = 0;
    rstN        = 1'b0;
    inValid     = 1'b1;
    inData      = 8'hFF;
    inCount     = 4'd8;
    inFlush     = 1'b0;
    outReady    = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_inReady", 32'(inReady), 32'd0);
      check("reset_outValid", 32'(outValid), 32'd0);
      check("reset_outData", 32'(outData), 32'h0000);
    end
    rstN = 1'b1;
    tick();
    check("release_inReady", 32'(inReady), 32'd1);
    inValid = 1'b0;

    sendBeat(8'hAB, 4'd8, 1'b0);
    check("aligned_first_noValid", 32'(outValid), 32'd0);
    sendBeat(8'hCD, 4'd8, 1'b0);
    check("aligned_valid", 32'(outValid), 32'd1);
    check("aligned_data", 32'(outData), 32'hCDAB);
    check("aligned_count", 32'(outCount), 32'd16);
    tick();
    check("aligned_consumed", 32'(outValid), 32'd0);

    sendBeat(8'h05, 4'd4, 1'b0);
    sendBeat(8'hFF, 4'd8, 1'b0);
    sendBeat(8'h03, 4'd4, 1'b0);
    check("unaligned_data", 32'(outData), 32'h3FF5);
    check("unaligned_count", 32'(outCount), 32'd16);
    tick();
    check("unaligned_empty", 32'(outValid), 32'd0);
    check("unaligned_ready", 32'(inReady), 32'd1);

    outReady = 1'b0;
    sendBeat(8'h11, 4'd8, 1'b0);
    sendBeat(8'h22, 4'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(outValid), 32'd1);
      check("bp_data", 32'(outData), 32'h2211);
      check("bp_inReady", 32'(inReady), 32'd0);
      tick();
    end
    outReady = 1'b1;
    tick();
    check("bp_consumed", 32'(outValid), 32'd0);

    sendBeat(8'h07, 4'd3, 1'b1);
    check("flush_valid", 32'(outValid), 32'd1);
    check("flush_data", 32'(outData), 32'h0007);
    check("flush_count", 32'(outCount), 32'd3);
    check("flush_inReady", 32'(inReady), 32'd0);
    tick();
    check("flush_done_ready", 32'(inReady), 32'd1);
    check("flush_done_valid", 32'(outValid), 32'd0);

    outReady = 1'b0;
    sendBeat(8'hEF, 4'd8, 1'b0);
    sendBeat(8'hBE, 4'd8, 1'b0);
    check("simul_word", 32'(outData), 32'hBEEF);
    inValid  = 1'b1;
    inData   = 8'hA5;
    inCount  = 4'd8;
    outReady = 1'b1;
    check("simul_blocked", 32'(inReady), 32'd0);
    tick();
    check("simul_reopen", 32'(inReady), 32'd1);
    check("simul_drained", 32'(outValid), 32'd0);
    tick();
    inValid = 1'b0;
    sendBeat(8'h5A, 4'd8, 1'b0);
    check("simul_data", 32'(outData), 32'h5AA5);
    tick();

    sendBeat(8'h3C, 4'd8, 1'b0);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    check("midreset_valid", 32'(outValid), 32'd0);
    check("midreset_ready", 32'(inReady), 32'd1);
    sendBeat(8'hFF, 4'd0, 1'b0);
    sendBeat(8'h12, 4'd8, 1'b0);
    check("zerocount_noValid", 32'(outValid), 32'd0);
    sendBeat(8'h34, 4'd15, 1'b0);
    check("clamp_data", 32'(outData), 32'h3412);
    check("clamp_count", 32'(outCount), 32'd16);
    tick();
    check("clamp_consumed", 32'(outValid), 32'd0);

    for (int i = 0; i < 600; i++) begin
      inValid  = ($urandom_range(0, 3) != 0);
      inData   = 8'($urandom);
      inCount  = 4'($urandom_range(0, 10));
      inFlush  = ($urandom_range(0, 7) == 0);
      outReady = ($urandom_range(0, 3) != 0);
      modelCycle();
    end

    inValid  = 1'b1;
    inData   = 8'h00;
    inCount  = 4'd0;
    inFlush  = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 60; i++) begin
      accepted = inValid && inReady;
      modelCycle();
      if (accepted) begin
        inValid = 1'b0;
        inFlush = 1'b0;
      end
    end
    check("drain_queue_empty", 32'(bitsQ.size()), 32'd0);
    check("drain_outValid", 32'(outValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bit_packer.md
Name: bit_packer

Overview:
- Packs variable-length input fragments, LSB-first and contiguous, into full OUTPUTWIDTH words.
- Sits directly upstream of the shared rotator and reuses it to place each fragment at the current fill position in a wide accumulator.
- Valid/ready handshake on both sides; a flush mechanism emits the final partial word.

Parameters:
INPUTWIDTH, 16, input data width in bits; power of two, multiple of SHIFTBITS_PER_STEP
OUTPUTWIDTH, 32, output word width in bits; power of two, >= INPUTWIDTH
SHIFTBITS_PER_STEP, 1, packing granularity in bits (one "unit"); all counts are in units

Ports:
clk  input  1  clock
rstN  input  1  synchronous active-low reset
inValid  input  1  input fragment valid
inReady  output  1  input fragment accepted when inValid && inReady
inData  input  INPUTWIDTH  fragment; valid units start at bit 0
inCount  input  $clog2(INPUTWIDTH/SHIFTBITS_PER_STEP)+1  number of valid units in inData, 0..IN_UNITS
inFlush  input  1  qualifies the accepted fragment as the last one of a stream
outValid  output  1  output word valid
outReady  input  1  output word consumed when outValid && outReady
outData  output  OUTPUTWIDTH  packed word; unused upper units are zero
outCount  output  $clog2(OUTPUTWIDTH/SHIFTBITS_PER_STEP)+1  valid units in outData (OUT_UNITS for full words)

Behaviour:
- One clock; reset is synchronous and active-low on rstN.
- Reset values: acc=0, fill=0, state=FILL, outValid=0, outData=0, outCount=0. inReady=0 while rstN is low.
- Accumulator acc is ACCW = OUTPUTWIDTH+INPUTWIDTH bits wide. fill is measured in units, range 0..OUT_UNITS+IN_UNITS.
- Placement: inData is masked to inCount units, zero-extended to ACCW, then rotated left by fill units (rotationRight = ACCW_UNITS-fill, mod ACCW_UNITS) and OR-ed into acc.
- States:
  - FILL: inReady = (fill < OUT_UNITS).
  - DRAIN: inReady = 0.
- Output side:
  - In FILL: outValid = (fill >= OUT_UNITS), outData = acc[OUTPUTWIDTH-1:0], outCount = OUT_UNITS.
  - In DRAIN: outValid = (fill != 0), outCount = min(fill, OUT_UNITS).
  - All outputs decode from registers only; there is no combinational input-to-output path.
- Output handshake: acc shifts right by OUTPUTWIDTH (zero fill), fill -= min(fill, OUT_UNITS).
- Simultaneous input and output handshake in one cycle: apply the output shift first, then place the fragment at (fill - OUT_UNITS).
- Stability: while outValid && !outReady, outData and outCount hold stable. New fragments only land at unit positions >= OUT_UNITS, so the output bits cannot change.
- Latency: a fragment accepted in cycle N is visible on outData no earlier than cycle N+1.
- inCount=0 is legal: the beat is accepted and fill is unchanged. inCount > IN_UNITS is clamped to IN_UNITS.
- Flush:
  - An accepted beat with inFlush=1 moves the state to DRAIN next cycle.
  - In DRAIN, full words and then the zero-padded partial word are emitted.
  - When fill reaches 0, the state returns to FILL.
  - A flush with fill=0 after placement returns to FILL with no output beat.
- Reset mid-stream discards acc contents with no output beat.

Decomposition:
- Package bit_packer_pkg:
  - state enum {FILL, DRAIN};
  - functions for IN_UNITS, OUT_UNITS, ACCW, ACCW_UNITS;
  - count-width localparams.
- Sub-module: one barrelShifterRight instance (INPUTWIDTH=OUTPUTWIDTH=ACCW, same SHIFTBITS_PER_STEP), connected through a rotatorConnect interface, for fragment placement.
- Masking, fill arithmetic and the FSM stay in bit_packer.

Test Plan:
- Config for all scenarios: INPUTWIDTH=8, OUTPUTWIDTH=16, SHIFTBITS_PER_STEP=1.
- Reset: rstN=0 for 3 cycles with inValid=1 -> inReady=0, outValid=0, outData=0x0000. The cycle after release -> inReady=1.
- Aligned pack: 0xAB/8 then 0xCD/8, outReady=1 -> one cycle after the second accept, outValid=1, outData=0xCDAB, outCount=16.
- Unaligned pack: 0x5/4, 0xFF/8, 0x3/4 -> outData=0x3FF5. fill returns to 0 after consume.
- Backpressure: outReady=0 with 0x11/8, 0x22/8 -> outValid=1 and outData=0x2211 held stable; inReady=0 (fill=16) until outReady=1.
- Flush: 0x7/3 with inFlush=1 -> next cycle outValid=1, outData=0x0007, outCount=3, inReady=0. After consume, state=FILL and inReady=1.
- Simultaneous handshakes: fill=16 (0xBEEF ready), outReady=1, 0xA5/8 offered -> inReady=0 that cycle. Next cycle fill=0 and 0xA5 is accepted; a later 0x5A/8 yields outData=0x5AA5.
